// File: rtl/fetch_queue_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fetch_queue_unit
// Purpose  : Instruction fetch stage with a prefetch queue. Issues in-order
//            instruction-memory requests from a private fetch PC, tags each
//            returned instruction with its PC, and buffers it in a DEPTH-entry
//            queue that decode drains under valid/ready back-pressure. A
//            redirect flushes the queue and discards responses in flight.
// Ports    : clock, reset (async, active-low)
//            NewPC, PCSelector            - redirect target / redirect strobe
//            imem_req_valid/ready, addr   - request channel
//            imem_resp_valid, resp_data   - in-order response channel
//            out_valid/ready, out_instr,
//            out_pc, out_pc_plus8         - decode-side queue head
// Revision : 1.0 - initial release
// ============================================================================
module fetch_queue_unit #(
    parameter int               WIDTH    = 32,
    parameter int               DEPTH    = 4,
    parameter int               STEP     = 4,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] NewPC,
    input  logic             PCSelector,
    output logic             imem_req_valid,
    input  logic             imem_req_ready,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_resp_valid,
    input  logic [WIDTH-1:0] imem_resp_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_instr,
    output logic [WIDTH-1:0] out_pc,
    output logic [WIDTH-1:0] out_pc_plus8
);

    localparam int               c_PTR_W   = $clog2(DEPTH);
    // Counters must represent the value DEPTH itself, hence DEPTH+1.
    localparam int               c_CNT_W   = $clog2(DEPTH + 1);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);
    localparam logic [c_CNT_W:0]   c_DEPTH   = (c_CNT_W + 1)'(DEPTH);
    localparam logic [WIDTH-1:0]   c_STEP    = WIDTH'(STEP);
    localparam logic [WIDTH-1:0]   c_EIGHT   = WIDTH'(8);

    logic [WIDTH-1:0]   r_fetch_pc;
    logic [WIDTH-1:0]   r_resp_pc;   // PC tag for the next kept response
    logic [c_CNT_W-1:0] r_inflight;
    logic [c_CNT_W-1:0] r_drop;
    logic [c_CNT_W-1:0] r_count;
    logic [c_PTR_W-1:0] r_wptr;
    logic [c_PTR_W-1:0] r_rptr;
    logic [WIDTH-1:0]   r_instr_q [DEPTH];
    logic [WIDTH-1:0]   r_pc_q    [DEPTH];

    logic [c_CNT_W:0]   w_used;
    logic               w_req_fire;
    logic               w_resp_ok;
    logic               w_resp_drop;
    logic               w_push;
    logic               w_pop;

    // Credits: entries already queued plus responses that will be kept.
    // Stale (to-be-dropped) responses never occupy a slot, so they are
    // subtracted; this bound makes overflow impossible.
    assign w_used = {1'b0, r_count} + {1'b0, r_inflight} - {1'b0, r_drop};

    // Gated with reset so no request is advertised while the block is held.
    assign imem_req_valid = reset && !PCSelector && (w_used < c_DEPTH);
    assign imem_addr      = r_fetch_pc;
    assign w_req_fire     = imem_req_valid && imem_req_ready;

    // A response with nothing outstanding is a protocol violation: ignored.
    assign w_resp_ok   = imem_resp_valid && (r_inflight != '0);
    assign w_resp_drop = w_resp_ok && (r_drop != '0);
    assign w_push      = w_resp_ok && !w_resp_drop && !PCSelector;

    assign out_valid = (r_count != '0);
    assign w_pop     = out_valid && out_ready && !PCSelector;

    // Head fields read as zero whenever the queue is empty (including reset).
    assign out_instr    = out_valid ? r_instr_q[r_rptr] : '0;
    assign out_pc       = out_valid ? r_pc_q[r_rptr] : '0;
    assign out_pc_plus8 = out_valid ? (r_pc_q[r_rptr] + c_EIGHT) : '0;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_fetch_pc <= RESET_PC;
            r_resp_pc  <= RESET_PC;
            r_inflight <= '0;
            r_drop     <= '0;
            r_count    <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
        end else if (PCSelector) begin
            // Every request still outstanding after this cycle belongs to the
            // old path, so drop is re-derived from inflight rather than
            // accumulated; back-to-back redirects stay consistent.
            r_fetch_pc <= NewPC;
            r_resp_pc  <= NewPC;
            r_inflight <= r_inflight - {{(c_CNT_W-1){1'b0}}, w_resp_ok};
            r_drop     <= r_inflight - {{(c_CNT_W-1){1'b0}}, w_resp_ok};
            r_count    <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
        end else begin
            if (w_req_fire) begin
                r_fetch_pc <= r_fetch_pc + c_STEP;
            end
            r_inflight <= r_inflight
                          + {{(c_CNT_W-1){1'b0}}, w_req_fire}
                          - {{(c_CNT_W-1){1'b0}}, w_resp_ok};
            if (w_resp_drop) begin
                r_drop <= r_drop - c_CNT_ONE;
            end
            if (w_push) begin
                r_wptr    <= r_wptr + c_PTR_ONE;
                r_resp_pc <= r_resp_pc + c_STEP;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_PTR_ONE;
            end
            r_count <= r_count
                       + {{(c_CNT_W-1){1'b0}}, w_push}
                       - {{(c_CNT_W-1){1'b0}}, w_pop};
        end
    end

    // Queue payload needs no reset: it is only observed through out_valid.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_instr_q[r_wptr] <= imem_resp_data;
            r_pc_q[r_wptr]    <= r_resp_pc;
        end
    end

endmodule
`default_nettype wire

// File: doc/fetch_queue_unit.md
Name: fetch_queue_unit

Overview:
- Parametrised successor to the single-register fetch stage.
- Keeps its own fetch PC and issues instruction-memory requests over a valid/ready handshake. The memory may have variable latency but returns responses in order.
- Buffers returned instructions, tagged with their PC, in a DEPTH-entry prefetch queue drained by decode under valid/ready back-pressure.
- A redirect (branch/exception) flushes the queue and discards every response still in flight.

Parameters:
WIDTH, 32, PC and instruction width in bits
DEPTH, 4, prefetch queue entries; power of 2, >= 2
STEP, 4, byte increment between sequential fetches
RESET_PC, 0, fetch address after reset

Ports:
clock  in  1  single clock; all state updates on rising edge
reset  in  1  asynchronous, active-low reset
NewPC  in  WIDTH  redirect target
PCSelector  in  1  1 = redirect to NewPC this cycle
imem_req_valid  out  1  request valid
imem_req_ready  in  1  memory accepts request
imem_addr  out  WIDTH  request address (= fetch PC)
imem_resp_valid  in  1  one in-order response this cycle
imem_resp_data  in  WIDTH  response instruction
out_valid  out  1  queue head valid
out_ready  in  1  decode accepts head
out_instr  out  WIDTH  head instruction
out_pc  out  WIDTH  head PC
out_pc_plus8  out  WIDTH  head PC + 8, modulo 2^WIDTH

Behaviour:

Reset (reset = 0, async):
- fetch_pc = RESET_PC.
- inflight = 0, drop = 0.
- Queue empty; out_valid = 0; imem_req_valid = 0.
- out_instr, out_pc and out_pc_plus8 = 0.
- Reset applied mid-operation abandons all in-flight requests. The memory side is reset by the same signal.

State:
- fetch_pc: WIDTH bits.
- inflight: 0..DEPTH, requests accepted but not yet answered.
- drop: 0..DEPTH, responses still to be discarded, drop <= inflight.
- Queue: count 0..DEPTH, read/write pointers wrap modulo DEPTH.

Issue:
- imem_req_valid = !PCSelector && (count + inflight - drop < DEPTH).
- Combinational; ignores imem_req_ready.
- imem_addr = fetch_pc.
- req_fire = imem_req_valid && imem_req_ready.
- On req_fire: fetch_pc += STEP (wraps modulo 2^WIDTH) and inflight += 1.
- The credit rule guarantees the queue never overflows.

Response:
- When imem_resp_valid and drop > 0: discard the response; drop -= 1.
- Otherwise push {imem_resp_data, pc tag} into the queue.
  - The pc tag comes from a tag FIFO of issued addresses, or equivalently a response-PC counter advanced by STEP, reloaded on redirect.
- inflight -= 1 on every response.
- A response arriving with inflight == 0 is a protocol violation: ignore it, no state change.

Dequeue:
- out_valid = (count != 0).
- Head fields are driven from the queue registers.
- A pop occurs when out_valid && out_ready.
- Push and pop in the same cycle leave count unchanged. This is legal when the queue is full.

Redirect (PCSelector = 1), taking priority over issue and pop:
- fetch_pc <= NewPC; queue cleared (count = 0, pointers = 0).
- A response arriving in the redirect cycle is discarded.
- drop <= inflight - imem_resp_valid.
- inflight <= inflight - imem_resp_valid.
- No request is issued in the redirect cycle.
- Next cycle: imem_addr = NewPC and out_valid = 0.
- Back-to-back redirects: the last one wins. drop accumulates correctly because drop is recomputed from inflight each time.

Latency:
- Minimum from request accept to out_valid is 2 cycles, for a memory that responds one cycle after accept.
- With continuous ready and 1-cycle memory, throughput is 1 instruction per cycle once the pipeline is primed.

Test Plan:
1. Reset release, RESET_PC = 0x100, 1-cycle memory returning addr^0xFFFF, out_ready = 1 -> out_pc sequence 0x100, 0x104, 0x108… one per cycle; out_instr = 0xFEFF, 0xFEFB…; out_pc_plus8 = 0x108, 0x10C…
2. out_ready = 0 for 10 cycles -> exactly DEPTH = 4 requests issued, then imem_req_valid = 0; queue full. Raise out_ready -> 0x100..0x10C drain in order, issue resumes at 0x110 with no gap or duplicate.
3. 3-cycle memory with 3 requests in flight, PCSelector = 1, NewPC = 0x2000 -> next cycle imem_addr = 0x2000 and out_valid = 0. The 3 stale responses are discarded; the first out_pc = 0x2000.
4. Response and redirect in the same cycle, plus a redirect on the cycle after -> no stale instruction ever appears; the final target's instruction appears first.
5. fetch_pc = 0xFFFFFFFC -> next imem_addr = 0x00000000; out_pc_plus8 of 0xFFFFFFFC = 0x00000004.
6. reset asserted mid-burst with 2 requests in flight -> all outputs zero immediately (async). After release, fetch restarts at RESET_PC with inflight = 0.
